// File: rtl/lloyd_iter_ctrl_if.sv
// Datapath bus between the Max-Lloyd sequencer and its sample RAM, bin search,
// accumulator, divider and boundary table.
interface lloyd_iter_ctrl_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned FX_W   = 16,
    parameter int unsigned ADDR_W = 8
);
    logic              smp_rd_en;
    logic [ADDR_W-1:0] smp_addr;
    logic [DATA_W-1:0] smp_data;

    logic              srch_req;
    logic [FX_W-1:0]   srch_sample;
    logic              srch_ack;
    logic [4:0]        srch_bin;

    logic              acc_clr;
    logic              acc_inc;
    logic [4:0]        acc_bin;
    logic [31:0]       acc_sum;
    logic [31:0]       acc_count;

    logic              div_start;
    logic [31:0]       div_num;
    logic [31:0]       div_den;
    logic              div_done;
    logic [31:0]       div_quot;

    logic              bnd_we;
    logic [4:0]        bnd_idx;
    logic [FX_W-1:0]   bnd_wdata;

    modport master (
        output smp_rd_en, smp_addr, srch_req, srch_sample, acc_clr, acc_inc, acc_bin,
               div_start, div_num, div_den, bnd_we, bnd_idx, bnd_wdata,
        input  smp_data, srch_ack, srch_bin, acc_sum, acc_count, div_done, div_quot
    );

    modport slave (
        input  smp_rd_en, smp_addr, srch_req, srch_sample, acc_clr, acc_inc, acc_bin,
               div_start, div_num, div_den, bnd_we, bnd_idx, bnd_wdata,
        output smp_data, srch_ack, srch_bin, acc_sum, acc_count, div_done, div_quot
    );
endinterface

// File: rtl/lloyd_iter_ctrl.sv
// Max-Lloyd quantiser iteration sequencer: classify/accumulate all samples, divide
// per bin to form the bin means, rewrite interior boundaries, test for convergence.
module lloyd_iter_ctrl #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned FX_W     = 16,
    parameter int unsigned NUM_DATA = 200,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned NUM_BINS = 20,
    parameter int          BIN_STEP = 2560,
    parameter int unsigned MAX_ITR  = 100,
    parameter int unsigned CONV_TOL = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       converged,
    output logic [7:0] itr_count,
    lloyd_iter_ctrl_if.master bus
);
    localparam int unsigned BIN_W  = 5;
    localparam int unsigned FRAC_W = FX_W - DATA_W;
    localparam int          BND_BASE = -(2 ** (FX_W - 1));
    localparam logic [BIN_W-1:0]  LAST_BIN  = BIN_W'(NUM_BINS - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_DATA - 1);
    localparam logic [7:0]        MAX_ITR_C = 8'(MAX_ITR);
    localparam logic [FX_W:0]     TOL_C     = (FX_W + 1)'(CONV_TOL);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_CLEAR, S_FETCH, S_WAIT_MEM, S_SEARCH, S_ACCUM,
        S_DIV_ISSUE, S_DIV_WAIT, S_BND_UPD, S_CHECK, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0]       idx_q;
    logic [BIN_W-1:0]        cnt_q;
    logic [DATA_W-1:0]       smp_q;
    logic [BIN_W-1:0]        bin_q;
    logic signed [FX_W-1:0]  a_q      [NUM_BINS];
    logic signed [FX_W-1:0]  shadow_q [NUM_BINS];
    logic [FX_W:0]           max_delta_q;
    logic [7:0]              itr_q;
    logic                    conv_q;

    logic signed [FX_W-1:0]  init_val;
    logic signed [FX_W-1:0]  a_hi, a_lo, shadow_cur, bnd_new;
    logic signed [FX_W:0]    pair_sum, diff;
    logic [FX_W:0]           abs_diff;
    logic                    cnt_last, count_zero;
    logic                    unused_quot_hi;

    assign unused_quot_hi = ^bus.div_quot[31:FX_W];

    // Boundary arithmetic: initial spacing, neighbour-mean midpoint (floor) and its move
    always_comb begin
        init_val   = FX_W'(BND_BASE + int'(cnt_q) * BIN_STEP);
        a_hi       = a_q[cnt_q];
        a_lo       = a_q[cnt_q - 5'd1];
        shadow_cur = shadow_q[cnt_q];
        pair_sum   = $signed({a_hi[FX_W-1], a_hi}) + $signed({a_lo[FX_W-1], a_lo});
        bnd_new    = FX_W'(pair_sum >>> 1);
        diff       = $signed({bnd_new[FX_W-1], bnd_new}) - $signed({shadow_cur[FX_W-1], shadow_cur});
        abs_diff   = diff[FX_W] ? $unsigned(-diff) : $unsigned(diff);
        cnt_last   = (cnt_q == LAST_BIN);
        count_zero = (bus.acc_count == 32'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start) state_d = S_INIT;
            S_INIT:      if (cnt_last) state_d = S_CLEAR;
            S_CLEAR:     state_d = S_FETCH;
            S_FETCH:     state_d = S_WAIT_MEM;
            S_WAIT_MEM:  state_d = S_SEARCH;
            S_SEARCH:    if (bus.srch_ack) state_d = S_ACCUM;
            S_ACCUM:     state_d = (idx_q == LAST_IDX) ? S_DIV_ISSUE : S_FETCH;
            S_DIV_ISSUE: begin
                if (!count_zero)   state_d = S_DIV_WAIT;
                else if (cnt_last) state_d = S_BND_UPD;
            end
            S_DIV_WAIT:  if (bus.div_done) state_d = cnt_last ? S_BND_UPD : S_DIV_ISSUE;
            S_BND_UPD:   if (cnt_last) state_d = S_CHECK;
            S_CHECK:     state_d = (max_delta_q <= TOL_C || 8'(itr_q + 8'd1) == MAX_ITR_C)
                                   ? S_DONE : S_CLEAR;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy            = (state_q != S_IDLE);
        done            = (state_q == S_DONE);
        converged       = conv_q;
        itr_count       = itr_q;
        bus.smp_rd_en   = 1'b0;
        bus.smp_addr    = '0;
        bus.srch_req    = 1'b0;
        bus.srch_sample = {smp_q, {FRAC_W{1'b0}}};
        bus.acc_clr     = 1'b0;
        bus.acc_inc     = 1'b0;
        bus.acc_bin     = '0;
        bus.div_start   = 1'b0;
        bus.div_num     = '0;
        bus.div_den     = '0;
        bus.bnd_we      = 1'b0;
        bus.bnd_idx     = '0;
        bus.bnd_wdata   = '0;
        case (state_q)
            S_INIT: begin
                bus.bnd_we    = 1'b1;
                bus.bnd_idx   = cnt_q;
                bus.bnd_wdata = init_val;
            end
            S_CLEAR:  bus.acc_clr = 1'b1;
            S_FETCH: begin
                bus.smp_rd_en = 1'b1;
                bus.smp_addr  = idx_q;
            end
            S_SEARCH: bus.srch_req = 1'b1;
            S_ACCUM: begin
                bus.acc_inc = 1'b1;
                bus.acc_bin = bin_q;
            end
            S_DIV_ISSUE, S_DIV_WAIT: begin
                // acc_bin stays on k so the divider operands hold for the whole divide
                bus.acc_bin   = cnt_q;
                bus.div_num   = bus.acc_sum;
                bus.div_den   = bus.acc_count;
                bus.div_start = (state_q == S_DIV_ISSUE) && !count_zero;
            end
            S_BND_UPD: begin
                bus.bnd_we    = 1'b1;
                bus.bnd_idx   = cnt_q;
                bus.bnd_wdata = bnd_new;
            end
            default: ;
        endcase
    end

    // Datapath registers: loop counters, captured sample/bin, bin means, boundary shadow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q       <= '0;
            cnt_q       <= '0;
            smp_q       <= '0;
            bin_q       <= '0;
            max_delta_q <= '0;
            itr_q       <= '0;
            conv_q      <= 1'b0;
            for (int i = 0; i < int'(NUM_BINS); i++) begin
                a_q[i]      <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    itr_q  <= '0;
                    conv_q <= 1'b0;
                    cnt_q  <= 5'd1;
                    for (int i = 0; i < int'(NUM_BINS); i++) a_q[i] <= '0;
                end
                S_INIT: begin
                    shadow_q[cnt_q] <= init_val;
                    cnt_q           <= cnt_q + 5'd1;
                end
                S_CLEAR: begin
                    idx_q       <= '0;
                    max_delta_q <= '0;
                end
                S_WAIT_MEM: smp_q <= bus.smp_data;
                S_SEARCH:   if (bus.srch_ack) bin_q <= bus.srch_bin;
                S_ACCUM: begin
                    if (idx_q == LAST_IDX) cnt_q <= '0;
                    else                   idx_q <= idx_q + ADDR_W'(1);
                end
                S_DIV_ISSUE: if (count_zero) cnt_q <= cnt_last ? 5'd1 : cnt_q + 5'd1;
                S_DIV_WAIT: if (bus.div_done) begin
                    a_q[cnt_q] <= bus.div_quot[FX_W-1:0];
                    cnt_q      <= cnt_last ? 5'd1 : cnt_q + 5'd1;
                end
                S_BND_UPD: begin
                    shadow_q[cnt_q] <= bnd_new;
                    if (abs_diff > max_delta_q) max_delta_q <= abs_diff;
                    cnt_q <= cnt_q + 5'd1;
                end
                S_CHECK: begin
                    itr_q <= itr_q + 8'd1;
                    if (max_delta_q <= TOL_C) conv_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lloyd_iter_ctrl.sv
// Directed bench for lloyd_iter_ctrl with RAM, search, accumulator and divider stubs.
module tb_lloyd_iter_ctrl;
    localparam int unsigned NDATA = 24;

    typedef struct {
        int pat;   int bin;  int sdly; int lat;
        bit alt;   bit noise;
        int e_itr; bit e_conv; int e_div;
        int e_b3;  int e_b4;   int e_b12;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start_main, start_noise, start;
    logic busy, done, converged;
    logic [7:0] itr_count;
    assign start = start_main | start_noise;

    lloyd_iter_ctrl_if #(.DATA_W(8), .FX_W(16), .ADDR_W(8)) bus ();

    lloyd_iter_ctrl #(.NUM_DATA(NDATA)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .converged(converged), .itr_count(itr_count), .bus(bus)
    );

    int       cfg_sdly, cfg_lat, cfg_bin;
    bit       cfg_alt, cfg_noise, mon_clr;
    logic [7:0] mem [256];

    // Sample RAM: one-cycle read latency
    always @(posedge clk) if (bus.smp_rd_en) bus.smp_data <= mem[bus.smp_addr];

    // Bin search: acknowledges after cfg_sdly extra cycles (0 = same cycle)
    int swait = 0;
    always @(posedge clk) swait <= (bus.srch_req && !bus.srch_ack) ? swait + 1 : 0;
    assign bus.srch_ack = bus.srch_req && (swait >= cfg_sdly);
    assign bus.srch_bin = 5'(cfg_bin);

    // Accumulator
    logic signed [31:0] m_sum [32];
    logic [31:0]        m_cnt [32];
    always @(posedge clk) begin
        if (bus.acc_clr) begin
            for (int i = 0; i < 32; i++) begin
                m_sum[i] <= 0;
                m_cnt[i] <= 0;
            end
        end else if (bus.acc_inc) begin
            m_sum[bus.acc_bin] <= m_sum[bus.acc_bin] + 32'($signed(bus.srch_sample));
            m_cnt[bus.acc_bin] <= m_cnt[bus.acc_bin] + 1;
        end
    end
    assign bus.acc_sum   = m_sum[bus.acc_bin];
    assign bus.acc_count = m_cnt[bus.acc_bin];

    // Divider: quotient after cfg_lat cycles; optional spurious done pulses while idle
    bit pend = 1'b0;
    int dcnt = 0;
    logic [31:0] dq;
    always @(posedge clk) begin
        bus.div_done <= 1'b0;
        if (bus.div_start) begin
            pend <= 1'b1;
            dcnt <= 1;
            if (cfg_alt)                dq <= itr_count[0] ? 32'h2000 : 32'h1000;
            else if (bus.div_den == 0)  dq <= 32'h0;
            else                        dq <= 32'($signed(bus.div_num) / $signed(bus.div_den));
        end else if (pend) begin
            if (dcnt >= cfg_lat) begin
                bus.div_done <= 1'b1;
                bus.div_quot <= dq;
                pend         <= 1'b0;
            end else begin
                dcnt <= dcnt + 1;
            end
        end else if (cfg_noise && $urandom_range(0, 4) == 0) begin
            bus.div_done <= 1'b1;
            bus.div_quot <= 32'h7FFF;
        end
    end

    // Extra start pulses while the run is in progress
    always @(posedge clk)
        start_noise <= cfg_noise && busy && !done && ($urandom_range(0, 7) == 0);

    // Protocol monitor and boundary table
    int n_inc, n_div, n_zden, n_done, n_ack, n_hold, n_bw, init_err;
    logic [15:0] first_w, last_w, prev_s;
    logic [31:0] cap_num, cap_den;
    bit req_wait;
    logic signed [15:0] bnd_mem [21];
    always @(negedge clk) begin
        if (mon_clr) begin
            n_inc <= 0; n_div <= 0; n_zden <= 0; n_done <= 0; n_ack <= 0;
            n_hold <= 0; n_bw <= 0; init_err <= 0; req_wait <= 1'b0;
            for (int i = 0; i < 21; i++) bnd_mem[i] <= 16'sd0;
        end else begin
            if (bus.acc_inc) n_inc <= n_inc + 1;
            if (bus.srch_req && bus.srch_ack) n_ack <= n_ack + 1;
            if (done) n_done <= n_done + 1;
            if (bus.div_start) begin
                n_div   <= n_div + 1;
                cap_num <= bus.div_num;
                cap_den <= bus.div_den;
                if (bus.div_den == 0) n_zden <= n_zden + 1;
                if (pend) n_hold <= n_hold + 1;
            end
            if (pend && (bus.div_num != cap_num || bus.div_den != cap_den)) n_hold <= n_hold + 1;
            if (req_wait && (!bus.srch_req || bus.srch_sample != prev_s)) n_hold <= n_hold + 1;
            if (bus.bnd_we) begin
                bnd_mem[bus.bnd_idx] <= bus.bnd_wdata;
                if (n_bw == 0)  first_w <= bus.bnd_wdata;
                if (n_bw == 18) last_w  <= bus.bnd_wdata;
                if (n_bw < 19 && (int'(bus.bnd_idx) != n_bw + 1 ||
                    bus.bnd_wdata != 16'((n_bw + 1) * 2560 - 32768)))
                    init_err <= init_err + 1;
                n_bw <= n_bw + 1;
            end
            req_wait <= bus.srch_req && !bus.srch_ack;
            prev_s   <= bus.srch_sample;
        end
    end

    int n_chk = 0, n_pass = 0;

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
        else             n_pass++;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(posedge clk); #1;
        mon_clr = 1'b0;
    endtask

    task automatic pulse_start();
        start_main = 1'b1;
        @(posedge clk); #1;
        start_main = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int ri);
        bit got;
        cfg_sdly = v.sdly; cfg_lat = v.lat; cfg_bin = v.bin;
        cfg_alt = v.alt;   cfg_noise = v.noise;
        for (int i = 0; i < 256; i++)
            mem[i] = (v.pat == 1 && i % 3 == 0) ? 8'hFF : 8'h00;
        clear_mon();
        pulse_start();
        got = 1'b0;
        for (int c = 0; c < 40000; c++) begin
            @(posedge clk); #1;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check($sformatf("r%0d_done_seen", ri), int'(got), 1);
        if (got) begin
            cfg_noise = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("r%0d_itr_count", ri), int'(itr_count), v.e_itr);
            check($sformatf("r%0d_converged", ri), int'(converged), int'(v.e_conv));
            check($sformatf("r%0d_busy_after", ri), int'(busy), 0);
            check($sformatf("r%0d_done_pulses", ri), n_done, 1);
            check($sformatf("r%0d_acc_inc", ri), n_inc, int'(NDATA) * v.e_itr);
            check($sformatf("r%0d_inc_vs_ack", ri), n_inc, n_ack);
            check($sformatf("r%0d_div_start", ri), n_div, v.e_div);
            check($sformatf("r%0d_zero_den", ri), n_zden, 0);
            check($sformatf("r%0d_hold_viol", ri), n_hold, 0);
            check($sformatf("r%0d_bnd_writes", ri), n_bw, 19 * (v.e_itr + 1));
            check($sformatf("r%0d_init_seq", ri), init_err, 0);
            check($sformatf("r%0d_init_first", ri), int'(first_w), 32'h8A00);
            check($sformatf("r%0d_init_last", ri), int'(last_w), 32'h3E00);
            check($sformatf("r%0d_bnd3", ri), int'(bnd_mem[3]), v.e_b3);
            check($sformatf("r%0d_bnd4", ri), int'(bnd_mem[4]), v.e_b4);
            check($sformatf("r%0d_bnd12", ri), int'(bnd_mem[12]), v.e_b12);
            check($sformatf("r%0d_bnd13", ri), int'(bnd_mem[13]), v.e_b12);
            check($sformatf("r%0d_bnd0_untouched", ri), int'(bnd_mem[0]), 0);
        end
    endtask

    vec_t vecs [5];
    bit   seen;

    initial begin
        //          pat bin sdly lat alt noise itr conv div  b3   b4   b12
        vecs[0] = '{0, 12, 0,  1,  1'b0, 1'b0, 2,   1'b1, 2,   0,   0,   0};
        vecs[1] = '{0, 12, 3,  17, 1'b0, 1'b0, 2,   1'b1, 2,   0,   0,   0};
        vecs[2] = '{1, 3,  1,  2,  1'b0, 1'b0, 2,   1'b1, 2,   -43, -43, 0};
        vecs[3] = '{0, 12, 0,  1,  1'b0, 1'b1, 2,   1'b1, 2,   0,   0,   0};
        vecs[4] = '{0, 12, 0,  1,  1'b1, 1'b0, 100, 1'b0, 100, 0,   0,   4096};

        rst_n = 1'b0; start_main = 1'b0; mon_clr = 1'b1;
        cfg_sdly = 0; cfg_lat = 1; cfg_bin = 12; cfg_alt = 1'b0; cfg_noise = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_itr_count", int'(itr_count), 0);
        check("rst_converged", int'(converged), 0);
        check("rst_bnd_we", int'(bus.bnd_we), 0);
        check("rst_srch_req", int'(bus.srch_req), 0);
        check("rst_acc_clr", int'(bus.acc_clr), 0);
        rst_n = 1'b1;
        mon_clr = 1'b0;

        // Reset while a slow search is outstanding
        cfg_sdly = 10;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        clear_mon();
        pulse_start();
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (bus.srch_req) begin
                seen = 1'b1;
                break;
            end
        end
        check("mid_search_reached", int'(seen), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_srch_req", int'(bus.srch_req), 0);
        check("midrst_smp_rd_en", int'(bus.smp_rd_en), 0);
        check("midrst_acc_inc", int'(bus.acc_inc), 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_no_done", n_done, 0);
        check("midrst_idle", int'(busy), 0);

        for (int r = 0; r < 5; r++) run_vec(vecs[r], r);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
